// File: rtl/ball_velocity_mv.sv
// rtl/ball_velocity_mv.sv - per-frame ball mover with velocity, friction, edge bounce and pixel render
//
// Ports:
//   i_clk, i_rst_n            pixel clock, asynchronous active-low reset
//   i_frame_strobe            one-cycle pulse per frame, starts an update from IDLE
//   i_up/i_down/i_left/i_right d-pad levels, active high
//   i_recenter                level request: return to start position, zero velocity
//   i_hpos, i_vpos, i_visible current raster position and active-video flag
//   o_rgb                     registered pixel colour (ball or black)
//   o_x, o_y, o_vx, o_vy      committed position and signed velocity
//   o_busy                    high while an update is in flight
//   o_bounce                  one-cycle pulse after a frame in which an axis clamped
module ball_velocity_mv #(
  parameter int         H_ACTIVE  = 640,
  parameter int         V_ACTIVE  = 480,
  parameter int         BALL_SIZE = 8,
  parameter int         MAX_SPEED = 4,
  parameter int         SPEED_W   = 4,
  parameter int         FRICTION  = 1,
  parameter int         START_X   = 316,
  parameter int         START_Y   = 236,
  parameter logic [2:0] COLOR     = 3'b111
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_strobe,
  input  logic               i_up,
  input  logic               i_down,
  input  logic               i_left,
  input  logic               i_right,
  input  logic               i_recenter,
  input  logic [9:0]         i_hpos,
  input  logic [9:0]         i_vpos,
  input  logic               i_visible,
  output logic [2:0]         o_rgb,
  output logic [9:0]         o_x,
  output logic [9:0]         o_y,
  output logic [SPEED_W-1:0] o_vx,
  output logic [SPEED_W-1:0] o_vy,
  output logic               o_busy,
  output logic               o_bounce
);

  typedef logic signed [SPEED_W-1:0] vel_t;
  typedef logic signed [10:0]        pos_t;

  localparam vel_t V_ONE  = vel_t'(1);
  localparam vel_t V_ZERO = vel_t'(0);
  localparam vel_t V_MAX  = vel_t'(MAX_SPEED);
  localparam vel_t V_MIN  = -V_MAX;
  localparam pos_t LIM_X  = pos_t'(H_ACTIVE - BALL_SIZE);
  localparam pos_t LIM_Y  = pos_t'(V_ACTIVE - BALL_SIZE);
  localparam pos_t P_ZERO = pos_t'(0);

  typedef enum logic [1:0] {IDLE, ACCEL, MOVE, BOUNCE} state_t;

  state_t     state;
  logic [9:0] x, y;
  vel_t       vx, vy;
  vel_t       wvx, wvy;       // working velocities, committed only in BOUNCE
  pos_t       px_n, py_n;     // unclamped next position, may be negative
  logic       b_up, b_down, b_left, b_right;

  function automatic vel_t accel(input vel_t v, input logic pos, input logic neg);
    if (pos && !neg)
      accel = (v >= V_MAX) ? v : v + V_ONE;
    else if (neg && !pos)
      accel = (v <= V_MIN) ? v : v - V_ONE;
    else if (FRICTION != 0)
      accel = (v > V_ZERO) ? v - V_ONE : (v < V_ZERO) ? v + V_ONE : v;
    else
      accel = v;
  endfunction

  function automatic pos_t sext(input vel_t v);
    sext = $signed({{(11-SPEED_W){v[SPEED_W-1]}}, v});
  endfunction

  function automatic vel_t vabs(input vel_t v);
    vabs = v[SPEED_W-1] ? -v : v;
  endfunction

  // Clamp results for the BOUNCE commit
  pos_t cx, cy;
  vel_t cvx, cvy;
  logic hit_x, hit_y;

  always_comb begin
    cx = px_n;  cvx = wvx;  hit_x = 1'b0;
    cy = py_n;  cvy = wvy;  hit_y = 1'b0;
    if (px_n < P_ZERO) begin
      cx = P_ZERO;  cvx = vabs(wvx);  hit_x = 1'b1;
    end else if (px_n > LIM_X) begin
      cx = LIM_X;   cvx = -vabs(wvx); hit_x = 1'b1;
    end
    if (py_n < P_ZERO) begin
      cy = P_ZERO;  cvy = vabs(wvy);  hit_y = 1'b1;
    end else if (py_n > LIM_Y) begin
      cy = LIM_Y;   cvy = -vabs(wvy); hit_y = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      x        <= 10'(START_X);
      y        <= 10'(START_Y);
      vx       <= V_ZERO;
      vy       <= V_ZERO;
      wvx      <= V_ZERO;
      wvy      <= V_ZERO;
      px_n     <= P_ZERO;
      py_n     <= P_ZERO;
      b_up     <= 1'b0;
      b_down   <= 1'b0;
      b_left   <= 1'b0;
      b_right  <= 1'b0;
      o_busy   <= 1'b0;
      o_bounce <= 1'b0;
    end else if (i_recenter) begin
      state    <= IDLE;
      x        <= 10'(START_X);
      y        <= 10'(START_Y);
      vx       <= V_ZERO;
      vy       <= V_ZERO;
      o_busy   <= 1'b0;
      o_bounce <= 1'b0;
    end else begin
      o_bounce <= 1'b0;
      case (state)
        IDLE: begin
          if (i_frame_strobe) begin
            b_up    <= i_up;
            b_down  <= i_down;
            b_left  <= i_left;
            b_right <= i_right;
            o_busy  <= 1'b1;
            state   <= ACCEL;
          end
        end
        ACCEL: begin
          wvx   <= accel(vx, b_right, b_left);
          wvy   <= accel(vy, b_down, b_up);
          state <= MOVE;
        end
        MOVE: begin
          px_n  <= $signed({1'b0, x}) + sext(wvx);
          py_n  <= $signed({1'b0, y}) + sext(wvy);
          state <= BOUNCE;
        end
        BOUNCE: begin
          x        <= cx[9:0];
          y        <= cy[9:0];
          vx       <= cvx;
          vy       <= cvy;
          o_bounce <= hit_x | hit_y;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Render from committed position only; 11-bit compares avoid x+BALL_SIZE overflow
  logic [10:0] h11, v11, x11, y11;
  logic        in_ball;

  always_comb begin
    h11     = {1'b0, i_hpos};
    v11     = {1'b0, i_vpos};
    x11     = {1'b0, x};
    y11     = {1'b0, y};
    in_ball = i_visible
              && (h11 >= x11) && (h11 < x11 + 11'(BALL_SIZE))
              && (v11 >= y11) && (v11 < y11 + 11'(BALL_SIZE));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_rgb <= 3'b000;
    else
      o_rgb <= in_ball ? COLOR : 3'b000;
  end

  assign o_x  = x;
  assign o_y  = y;
  assign o_vx = vx;
  assign o_vy = vy;

endmodule
